// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the D->E pipeline register of a 5-stage MIPS pipeline.
// Keeps a shadow {A3, we, Tnew} copy of the writers in E, M and W. From that copy
// and the D-stage Tuse/address bundle it derives stall/clr and the D forward selects.
module hazard_scoreboard #(
    parameter int unsigned CNT_W     = 16,
    parameter logic [1:0]  TUSE_NONE = 2'd3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       D_rsad,
    input  logic [4:0]       D_rtad,
    input  logic [1:0]       D_rs_Tuse,
    input  logic [1:0]       D_rt_Tuse,
    input  logic [4:0]       D_A3,
    input  logic             D_regwe,
    input  logic [1:0]       D_Tnew,
    output logic             stall,
    output logic             E_clr,
    output logic [1:0]       D_rs_fwd,
    output logic [1:0]       D_rt_fwd,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [4:0]       e_a3_q, m_a3_q, w_a3_q;
    logic             e_we_q, m_we_q, w_we_q;
    logic [1:0]       e_tnew_q, m_tnew_q, w_tnew_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic             stall_rs, stall_rt;

    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

    // The youngest matching writer decides; it must already hold its result (Tnew==0).
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] ad,
        input logic       e_we, input logic [4:0] e_a3, input logic [1:0] e_tnew,
        input logic       m_we, input logic [4:0] m_a3, input logic [1:0] m_tnew,
        input logic       w_we, input logic [4:0] w_a3
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (ad == 5'd0) begin
            sel = 2'd0;
        end else if (e_we && (e_a3 == ad)) begin
            sel = (e_tnew == 2'd0) ? 2'd1 : 2'd0;
        end else if (m_we && (m_a3 == ad)) begin
            sel = (m_tnew == 2'd0) ? 2'd2 : 2'd0;
        end else if (w_we && (w_a3 == ad)) begin
            sel = 2'd3;
        end
        return sel;
    endfunction

    // A read stalls when the youngest matching writer in E or M is not ready in time.
    function automatic logic need_stall(
        input logic [4:0] ad, input logic [1:0] tuse,
        input logic       e_we, input logic [4:0] e_a3, input logic [1:0] e_tnew,
        input logic       m_we, input logic [4:0] m_a3, input logic [1:0] m_tnew
    );
        logic st;
        st = 1'b0;
        if ((ad != 5'd0) && (tuse != TUSE_NONE)) begin
            if (e_we && (e_a3 == ad)) begin
                st = (e_tnew > tuse);
            end else if (m_we && (m_a3 == ad)) begin
                st = (m_tnew > tuse);
            end
        end
        return st;
    endfunction

    // Stall and forward decode from shadow state and the D bundle.
    always_comb begin
        stall_rs = need_stall(D_rsad, D_rs_Tuse, e_we_q, e_a3_q, e_tnew_q,
                              m_we_q, m_a3_q, m_tnew_q);
        stall_rt = need_stall(D_rtad, D_rt_Tuse, e_we_q, e_a3_q, e_tnew_q,
                              m_we_q, m_a3_q, m_tnew_q);
        stall    = stall_rs | stall_rt;
        E_clr    = stall;
        D_rs_fwd = 2'd0;
        D_rt_fwd = 2'd0;
        if (!stall) begin
            D_rs_fwd = fwd_sel(D_rsad, e_we_q, e_a3_q, e_tnew_q, m_we_q, m_a3_q, m_tnew_q,
                               w_we_q, w_a3_q);
            D_rt_fwd = fwd_sel(D_rtad, e_we_q, e_a3_q, e_tnew_q, m_we_q, m_a3_q, m_tnew_q,
                               w_we_q, w_a3_q);
        end
    end

    // Shadow pipeline advance and saturating stall counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            e_a3_q      <= 5'd0;
            e_we_q      <= 1'b0;
            e_tnew_q    <= 2'd0;
            m_a3_q      <= 5'd0;
            m_we_q      <= 1'b0;
            m_tnew_q    <= 2'd0;
            w_a3_q      <= 5'd0;
            w_we_q      <= 1'b0;
            w_tnew_q    <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            if (stall) begin
                e_a3_q   <= 5'd0;
                e_we_q   <= 1'b0;
                e_tnew_q <= 2'd0;
            end else begin
                e_a3_q   <= D_A3;
                e_we_q   <= D_regwe && (D_A3 != 5'd0);
                e_tnew_q <= D_Tnew;
            end
            m_a3_q   <= e_a3_q;
            m_we_q   <= e_we_q;
            m_tnew_q <= sat_dec(e_tnew_q);
            w_a3_q   <= m_a3_q;
            w_we_q   <= m_we_q;
            w_tnew_q <= sat_dec(m_tnew_q);
            if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a default-width instance plus a CNT_W=2
// instance sharing the same stimulus for the saturation checks.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rsad, D_rtad, D_A3;
    logic [1:0]  D_rs_Tuse, D_rt_Tuse, D_Tnew;
    logic        D_regwe;

    logic        stall, E_clr, s_stall, s_E_clr;
    logic [1:0]  D_rs_fwd, D_rt_fwd, s_rs_fwd, s_rt_fwd;
    logic [15:0] stall_cnt;
    logic [1:0]  s_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .D_rsad(D_rsad), .D_rtad(D_rtad),
        .D_rs_Tuse(D_rs_Tuse), .D_rt_Tuse(D_rt_Tuse), .D_A3(D_A3), .D_regwe(D_regwe),
        .D_Tnew(D_Tnew), .stall(stall), .E_clr(E_clr), .D_rs_fwd(D_rs_fwd),
        .D_rt_fwd(D_rt_fwd), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .D_rsad(D_rsad), .D_rtad(D_rtad),
        .D_rs_Tuse(D_rs_Tuse), .D_rt_Tuse(D_rt_Tuse), .D_A3(D_A3), .D_regwe(D_regwe),
        .D_Tnew(D_Tnew), .stall(s_stall), .E_clr(s_E_clr), .D_rs_fwd(s_rs_fwd),
        .D_rt_fwd(s_rt_fwd), .stall_cnt(s_cnt)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic [4:0] rsad, input logic [1:0] rs_tuse,
                         input logic [4:0] rtad, input logic [1:0] rt_tuse,
                         input logic [4:0] a3, input logic regwe, input logic [1:0] tnew);
        D_rsad = rsad; D_rs_Tuse = rs_tuse; D_rtad = rtad; D_rt_Tuse = rt_tuse;
        D_A3 = a3; D_regwe = regwe; D_Tnew = tnew;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [0:6] exp_st;
    logic [1:0] exp_fwd  [7];
    logic [1:0] exp_scnt [7];
    int         exp_mcnt [7];

    initial begin
        exp_st   = 7'b1101101;
        exp_fwd  = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd3, 2'd0};
        exp_scnt = '{2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        exp_mcnt = '{1, 2, 2, 3, 4, 4, 5};

        // Reset
        reset = 1'b0;
        set_d(0, 3, 0, 3, 0, 0, 0);
        step(); step();
        reset = 1'b1;
        set_d(5, 0, 0, 3, 0, 0, 0);
        #1;
        check("rst_stall", 16'(stall), 16'd0);
        check("rst_eclr", 16'(E_clr), 16'd0);
        check("rst_rsfwd", 16'(D_rs_fwd), 16'd0);
        check("rst_cnt", stall_cnt, 16'd0);
        step();

        // Load-use: lw $8 then add reading $8 with Tuse=1
        set_d(0, 3, 0, 3, 8, 1, 2);
        #1; check("lw_stall", 16'(stall), 16'd0);
        step();
        set_d(8, 1, 0, 3, 9, 1, 1);
        #1;
        check("lu_stall", 16'(stall), 16'd1);
        check("lu_eclr", 16'(E_clr), 16'd1);
        check("lu_rsfwd", 16'(D_rs_fwd), 16'd0);
        step();
        check("lu_stall2", 16'(stall), 16'd0);
        check("lu_eclr2", 16'(E_clr), 16'd0);
        check("lu_rsfwd2", 16'(D_rs_fwd), 16'd0);
        check("lu_cnt", stall_cnt, 16'd1);
        step();

        // Branch after ALU: ALU writes $3 (Tnew=1), beq reads $3 (Tuse=0)
        set_d(0, 3, 0, 3, 3, 1, 1);
        #1; check("alu_stall", 16'(stall), 16'd0);
        step();
        set_d(3, 0, 0, 3, 0, 0, 0);
        #1; check("br_stall", 16'(stall), 16'd1);
        step();
        check("br_stall2", 16'(stall), 16'd0);
        check("br_rsfwd", 16'(D_rs_fwd), 16'd2);
        check("br_cnt", stall_cnt, 16'd2);
        step();

        // jal-style Tnew=0 writer to $31, reader (rs==rt==31) held three cycles
        set_d(0, 3, 0, 3, 31, 1, 0);
        #1; check("jal_stall", 16'(stall), 16'd0);
        step();
        set_d(31, 0, 31, 0, 0, 0, 0);
        #1;
        check("jal_stall2", 16'(stall), 16'd0);
        check("jal_rs_e", 16'(D_rs_fwd), 16'd1);
        check("jal_rt_e", 16'(D_rt_fwd), 16'd1);
        step();
        check("jal_rs_m", 16'(D_rs_fwd), 16'd2);
        check("jal_rt_m", 16'(D_rt_fwd), 16'd2);
        step();
        check("jal_rs_w", 16'(D_rs_fwd), 16'd3);
        check("jal_rt_w", 16'(D_rt_fwd), 16'd3);
        step();

        // $0 hazard: writer to $0 is never tracked
        set_d(0, 3, 0, 3, 0, 1, 2);
        step();
        set_d(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("z_stall", 16'(stall), 16'd0);
        check("z_rsfwd", 16'(D_rs_fwd), 16'd0);
        check("z_rtfwd", 16'(D_rt_fwd), 16'd0);
        step();

        // Unused operand never stalls; Tnew==Tuse does not stall
        set_d(0, 3, 0, 3, 7, 1, 2);
        step();
        set_d(7, 3, 7, 2, 0, 0, 0);
        #1;
        check("nu_stall", 16'(stall), 16'd0);
        check("nu_rtfwd", 16'(D_rt_fwd), 16'd0);
        step();

        // E and M both write $4: E (Tnew=1) dominates M (Tnew=0)
        set_d(0, 3, 0, 3, 4, 1, 0);
        step();
        set_d(0, 3, 0, 3, 4, 1, 1);
        step();
        set_d(4, 1, 0, 3, 0, 0, 0);
        #1;
        check("em_stall", 16'(stall), 16'd0);
        check("em_rsfwd", 16'(D_rs_fwd), 16'd0);
        set_d(4, 0, 0, 3, 0, 0, 0);
        #1;
        check("em_stall2", 16'(stall), 16'd1);
        check("em_rsfwd2", 16'(D_rs_fwd), 16'd0);

        // Saturation: reader/writer of $6 with Tnew=2 held constant
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        set_d(6, 0, 0, 3, 6, 1, 2);
        #1;
        check("sat_stall0", 16'(stall), 16'd0);
        check("sat_cnt0", 16'(s_cnt), 16'd0);
        step();
        for (int i = 0; i < 7; i++) begin
            check($sformatf("sat_stall%0d", i + 1), 16'(s_stall), 16'(exp_st[i]));
            check($sformatf("sat_fwd%0d", i + 1), 16'(D_rs_fwd), 16'(exp_fwd[i]));
            step();
            check($sformatf("sat_scnt%0d", i + 1), 16'(s_cnt), 16'(exp_scnt[i]));
            check($sformatf("sat_mcnt%0d", i + 1), stall_cnt, 16'(exp_mcnt[i]));
        end

        // Reset mid-stall
        check("mid_stall_pre", 16'(stall), 16'd1);
        reset = 1'b0;
        step();
        check("mid_stall", 16'(stall), 16'd0);
        check("mid_eclr", 16'(E_clr), 16'd0);
        check("mid_scnt", 16'(s_cnt), 16'd0);
        check("mid_mcnt", stall_cnt, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
